rename_regfile_ckpt: RTL and testbench

- Parametrised architectural register file with a per-register ROB rename tag, for the out-of-order core. It serves the decoder's source-operand lookups and is updated by issue and ROB commit.
- Adds NRD read ports and NCKPT rename-table checkpoints, so a mispredicted branch restores only the rename state younger than it, not a full flush.
- Sits between decoder (lookups, issue), ROB (commit, restore) and branch unit (save/release).

---
 rtl/rename_regfile_ckpt_if.sv | 43 ++++
 rtl/rename_regfile_ckpt.sv | 86 ++++++++
 tb/tb_rename_regfile_ckpt.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/rename_regfile_ckpt_if.sv
// rename_regfile_ckpt_if: decoder/ROB/branch-unit bundle for the rename register file.
interface rename_regfile_ckpt_if #(
   parameter int XLEN   = 32,
   parameter int REG_AW = 5,
   parameter int ROB_AW = 4,
   parameter int NRD    = 2,
   parameter int NCKPT  = 4
);
   localparam int CK_AW = NCKPT > 1 ? $clog2(NCKPT) : 1;
   logic                       rdy_i;
   logic                       rollback_i;
   logic [NRD*REG_AW-1:0]      rd_addr_i;
   logic [NRD*XLEN-1:0]        rd_val_o;
   logic [NRD*(ROB_AW+1)-1:0]  rd_tag_o;
   logic                       issue_i;
   logic [REG_AW-1:0]          issue_rd_i;
   logic [ROB_AW-1:0]          issue_rob_pos_i;
   logic                       commit_i;
   logic [REG_AW-1:0]          commit_rd_i;
   logic [XLEN-1:0]            commit_val_i;
   logic [ROB_AW-1:0]          commit_rob_pos_i;
   logic                       ckpt_save_i;
   logic [CK_AW-1:0]           ckpt_save_id_i;
   logic                       ckpt_restore_i;
   logic [CK_AW-1:0]           ckpt_restore_id_i;
   logic                       ckpt_release_i;
   logic [CK_AW-1:0]           ckpt_release_id_i;
   logic [NCKPT-1:0]           ckpt_valid_o;
   modport master (
      output rdy_i, rollback_i, rd_addr_i, issue_i, issue_rd_i, issue_rob_pos_i,
             commit_i, commit_rd_i, commit_val_i, commit_rob_pos_i,
             ckpt_save_i, ckpt_save_id_i, ckpt_restore_i, ckpt_restore_id_i,
             ckpt_release_i, ckpt_release_id_i,
      input  rd_val_o, rd_tag_o, ckpt_valid_o
   );
   modport slave (
      input  rdy_i, rollback_i, rd_addr_i, issue_i, issue_rd_i, issue_rob_pos_i,
             commit_i, commit_rd_i, commit_val_i, commit_rob_pos_i,
             ckpt_save_i, ckpt_save_id_i, ckpt_restore_i, ckpt_restore_id_i,
             ckpt_release_i, ckpt_release_id_i,
      output rd_val_o, rd_tag_o, ckpt_valid_o
   );
endinterface

// File: rtl/rename_regfile_ckpt.sv
// rename_regfile_ckpt: register file with per-register ROB rename tags and tag-table checkpoints.
// Define RENAME_RF_COMMIT_BYPASS_EN to forward a latest-producer commit to same-cycle reads.
module rename_regfile_ckpt #(
   parameter int XLEN   = 32,
   parameter int REG_AW = 5,
   parameter int ROB_AW = 4,
   parameter int NRD    = 2,
   parameter int NCKPT  = 4
) (
   input logic clk,
   input logic rst,
   rename_regfile_ckpt_if.slave bus
);
   localparam int NREG = 2**REG_AW;
   localparam int TW   = ROB_AW + 1;
   logic [XLEN-1:0]  val_q [NREG];
   logic [XLEN-1:0]  val_d [NREG];
   logic [TW-1:0]    tag_q [NREG];
   logic [TW-1:0]    tag_d [NREG];
   logic [TW-1:0]    ck_q  [NCKPT][NREG];
   logic [TW-1:0]    ck_d  [NCKPT][NREG];
   logic [NCKPT-1:0] ckv_q, ckv_d;
   logic             commit_en, restore_ok;
   logic [TW-1:0]    ctag;
   assign commit_en  = bus.commit_i && bus.commit_rd_i != '0;
   assign ctag       = {1'b1, bus.commit_rob_pos_i};
   assign restore_ok = bus.ckpt_restore_i && ckv_q[bus.ckpt_restore_id_i];
   always_comb begin
      val_d = val_q;
      tag_d = tag_q;
      ck_d  = ck_q;
      ckv_d = ckv_q;
      // commit scrubs the live table and every image so restores never resurrect a retired tag
      if (commit_en) begin
         val_d[bus.commit_rd_i] = bus.commit_val_i;
         if (tag_q[bus.commit_rd_i] == ctag) tag_d[bus.commit_rd_i] = '0;
         for (int c = 0; c < NCKPT; c++)
            if (ck_q[c][bus.commit_rd_i] == ctag) ck_d[c][bus.commit_rd_i] = '0;
      end
      if (bus.rollback_i) begin
         tag_d = '{default: '0};
         ckv_d = '0;
      end else if (restore_ok) begin
         tag_d = ck_d[bus.ckpt_restore_id_i];
         ckv_d = '0;
         ckv_d[bus.ckpt_restore_id_i] = 1'b1;
      end else begin
         if (bus.issue_i && bus.issue_rd_i != '0) tag_d[bus.issue_rd_i] = {1'b1, bus.issue_rob_pos_i};
         if (bus.ckpt_release_i) ckv_d[bus.ckpt_release_id_i] = 1'b0;
         if (bus.ckpt_save_i) begin
            ck_d[bus.ckpt_save_id_i]  = tag_d;
            ckv_d[bus.ckpt_save_id_i] = 1'b1;
         end
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         val_q <= '{default: '0};
         tag_q <= '{default: '0};
         ck_q  <= '{default: '{default: '0}};
         ckv_q <= '0;
      end else if (bus.rdy_i) begin
         val_q <= val_d;
         tag_q <= tag_d;
         ck_q  <= ck_d;
         ckv_q <= ckv_d;
      end
   end
   always_comb begin
      bus.rd_val_o = '0;
      bus.rd_tag_o = '0;
      for (int k = 0; k < NRD; k++) begin
         bus.rd_val_o[k*XLEN +: XLEN] = val_q[bus.rd_addr_i[k*REG_AW +: REG_AW]];
         bus.rd_tag_o[k*TW +: TW]     = tag_q[bus.rd_addr_i[k*REG_AW +: REG_AW]];
`ifdef RENAME_RF_COMMIT_BYPASS_EN
         if (commit_en && bus.rd_addr_i[k*REG_AW +: REG_AW] == bus.commit_rd_i
             && tag_q[bus.commit_rd_i] == ctag) begin
            bus.rd_val_o[k*XLEN +: XLEN] = bus.commit_val_i;
            bus.rd_tag_o[k*TW +: TW]     = '0;
         end
`else
`endif
      end
   end
   assign bus.ckpt_valid_o = ckv_q;
endmodule

// File: tb/tb_rename_regfile_ckpt.sv
// tb_rename_regfile_ckpt: directed stimulus with a scoreboard queue drained by a negedge monitor.
module tb_rename_regfile_ckpt;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic smp = 1'b0;
   int   errors = 0;
   int   checks = 0;
   always #5 clk = ~clk;

   rename_regfile_ckpt_if #(.XLEN(32), .REG_AW(5), .ROB_AW(4), .NRD(2), .NCKPT(4)) bus ();
   rename_regfile_ckpt #(.XLEN(32), .REG_AW(5), .ROB_AW(4), .NRD(2), .NCKPT(4)) dut (
      .clk(clk), .rst(rst), .bus(bus)
   );

   typedef struct {
      string       nm;
      int          port;
      logic [31:0] val;
      logic [4:0]  tag;
      logic [3:0]  ckv;
   } entry_t;
   entry_t sbq[$];

   always @(negedge clk) begin
      if (smp) begin
         while (sbq.size() > 0) begin
            entry_t e;
            logic [31:0] av;
            logic [4:0]  at;
            e  = sbq.pop_front();
            av = bus.rd_val_o[e.port*32 +: 32];
            at = bus.rd_tag_o[e.port*5 +: 5];
            checks++;
            if (av !== e.val || at !== e.tag || bus.ckpt_valid_o !== e.ckv) begin
               errors++;
               $display("FAIL %s port%0d: got val=%h tag=%h ckv=%b, want val=%h tag=%h ckv=%b",
                        e.nm, e.port, av, at, bus.ckpt_valid_o, e.val, e.tag, e.ckv);
            end
         end
      end
   end

   task automatic idle();
      bus.rdy_i = 1'b1;             bus.rollback_i = 1'b0;        bus.rd_addr_i = '0;
      bus.issue_i = 1'b0;           bus.issue_rd_i = '0;          bus.issue_rob_pos_i = '0;
      bus.commit_i = 1'b0;          bus.commit_rd_i = '0;         bus.commit_val_i = '0;
      bus.commit_rob_pos_i = '0;    bus.ckpt_save_i = 1'b0;       bus.ckpt_save_id_i = '0;
      bus.ckpt_restore_i = 1'b0;    bus.ckpt_restore_id_i = '0;   bus.ckpt_release_i = 1'b0;
      bus.ckpt_release_id_i = '0;   smp = 1'b0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      idle();
   endtask

   task automatic issue(input logic [4:0] rd, input logic [3:0] pos);
      bus.issue_i = 1'b1; bus.issue_rd_i = rd; bus.issue_rob_pos_i = pos;
   endtask

   task automatic commit(input logic [4:0] rd, input logic [31:0] v, input logic [3:0] pos);
      bus.commit_i = 1'b1; bus.commit_rd_i = rd; bus.commit_val_i = v; bus.commit_rob_pos_i = pos;
   endtask

   task automatic chk(input string nm, input logic [4:0] a0, input logic [31:0] v0, input logic [4:0] t0,
                      input logic [4:0] a1, input logic [31:0] v1, input logic [4:0] t1, input logic [3:0] ckv);
      bus.rd_addr_i = {a1, a0};
      sbq.push_back('{nm, 0, v0, t0, ckv});
      sbq.push_back('{nm, 1, v1, t1, ckv});
      smp = 1'b1;
      step();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      idle();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      chk("reset", 5'd5, 0, 0, 5'd0, 0, 0, 4'b0000);
      issue(3, 6);                  step();
      chk("issue_x3", 5'd3, 0, 5'h16, 5'd0, 0, 0, 4'b0000);
      commit(3, 32'hDEADBEEF, 6);   step();
      chk("commit_match", 5'd3, 32'hDEADBEEF, 0, 5'd0, 0, 0, 4'b0000);
      issue(3, 6);                  step();
      commit(3, 32'hCAFEF00D, 2);   step();
      chk("commit_stale", 5'd3, 32'hCAFEF00D, 5'h16, 5'd0, 0, 0, 4'b0000);
      issue(4, 1);                  step();
      bus.ckpt_save_i = 1'b1; bus.ckpt_save_id_i = 2'd2; step();
      issue(4, 7);                  step();
      chk("before_restore", 5'd4, 0, 5'h17, 5'd3, 32'hCAFEF00D, 5'h16, 4'b0100);
      bus.ckpt_restore_i = 1'b1; bus.ckpt_restore_id_i = 2'd2; step();
      chk("restore2", 5'd4, 0, 5'h11, 5'd3, 32'hCAFEF00D, 5'h16, 4'b0100);
      issue(4, 1);                  step();
      bus.ckpt_save_i = 1'b1; bus.ckpt_save_id_i = 2'd0; step();
      commit(4, 32'h44, 1);         step();
      chk("commit_scrub", 5'd4, 32'h44, 0, 5'd0, 0, 0, 4'b0101);
      issue(4, 9);                  step();
      bus.ckpt_restore_i = 1'b1; bus.ckpt_restore_id_i = 2'd0; step();
      chk("restore_scrubbed", 5'd4, 32'h44, 0, 5'd3, 32'hCAFEF00D, 5'h16, 4'b0001);
      issue(6, 5);                  step();
      bus.ckpt_restore_i = 1'b1; bus.ckpt_restore_id_i = 2'd3; step();
      chk("restore_invalid", 5'd6, 0, 5'h15, 5'd4, 32'h44, 0, 4'b0001);
      bus.ckpt_save_i = 1'b1; bus.ckpt_save_id_i = 2'd1;
      bus.ckpt_release_i = 1'b1; bus.ckpt_release_id_i = 2'd1; step();
      chk("save_beats_release", 5'd6, 0, 5'h15, 5'd0, 0, 0, 4'b0011);
      bus.ckpt_release_i = 1'b1; bus.ckpt_release_id_i = 2'd0; step();
      chk("release0", 5'd6, 0, 5'h15, 5'd0, 0, 0, 4'b0010);
      commit(3, 32'h33, 6); issue(3, 8); step();
      chk("issue_beats_commit", 5'd3, 32'h33, 5'h18, 5'd0, 0, 0, 4'b0010);
      commit(0, 32'hFF, 4); issue(0, 4); step();
      chk("x0_ignored", 5'd0, 0, 0, 5'd0, 0, 0, 4'b0010);
      issue(9, 3);                  step();
      bus.ckpt_save_i = 1'b1; bus.ckpt_save_id_i = 2'd1; step();
      bus.rollback_i = 1'b1; commit(9, 32'd5, 3); issue(10, 2); step();
      chk("rollback", 5'd9, 32'd5, 0, 5'd3, 32'h33, 0, 4'b0000);
      chk("rollback_issue", 5'd10, 0, 0, 5'd6, 0, 0, 4'b0000);
      bus.rdy_i = 1'b0; issue(11, 1); commit(12, 32'd7, 0); step();
      chk("rdy_hold", 5'd11, 0, 0, 5'd12, 0, 0, 4'b0000);
      bus.ckpt_save_i = 1'b1; bus.ckpt_save_id_i = 2'd3; step();
      issue(13, 4); bus.ckpt_restore_i = 1'b1; bus.ckpt_restore_id_i = 2'd3; step();
      chk("restore_drops_issue", 5'd13, 0, 0, 5'd0, 0, 0, 4'b1000);
      issue(7, 2);                  step();
      commit(7, 32'h1234, 2);
`ifdef RENAME_RF_COMMIT_BYPASS_EN
      chk("commit_cycle_bypass", 5'd7, 32'h1234, 0, 5'd0, 0, 0, 4'b1000);
`else
      chk("commit_cycle_nobypass", 5'd7, 0, 5'h12, 5'd0, 0, 0, 4'b1000);
`endif
      chk("after_commit_x7", 5'd7, 32'h1234, 0, 5'd0, 0, 0, 4'b1000);
      @(posedge clk);
      checks++;
      if (sbq.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending entries, want 0", sbq.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
